// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: 2-FF synchronizers, per-phase persistence filter,
// Gray-step decode into registered up/down strobes, wrapping position and sticky error.
module quadrature_decoder #(
  parameter int N    = 8,
  parameter int FILT = 3
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_ce,
  input  logic         i_a,
  input  logic         i_b,
  input  logic         i_clr,
  output logic         o_count_up,
  output logic         o_count_down,
  output logic [N-1:0] o_position,
  output logic         o_dir,
  output logic         o_err
);

  localparam int CW = 4;

  logic [1:0]          r_sync_a;
  logic [1:0]          r_sync_b;
  logic [1:0]          w_sync;
  logic [1:0]          r_acc;
  logic [1:0][CW-1:0]  r_cnt;
  logic [1:0]          r_prev;
  logic                r_up;
  logic                r_dn;
  logic [N-1:0]        r_pos;
  logic                r_dir;
  logic                r_err;
  logic                w_step_up;
  logic                w_step_dn;
  logic                w_illegal;

  // Pin synchronizers, free-running regardless of clock enable
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync_a <= 2'b00;
      r_sync_b <= 2'b00;
    end else begin
      r_sync_a <= {r_sync_a[0], i_a};
      r_sync_b <= {r_sync_b[0], i_b};
    end
  end

  assign w_sync = {r_sync_a[1], r_sync_b[1]};

  // Persistence filter: accept a level after FILT consecutive enabled mismatches
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc <= 2'b00;
      r_cnt <= '0;
    end else if (i_ce) begin
      for (int i = 0; i < 2; i++) begin
        if (w_sync[i] != r_acc[i]) begin
          if (r_cnt[i] == CW'(FILT - 1)) begin
            r_acc[i] <= w_sync[i];
            r_cnt[i] <= {CW{1'b0}};
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= {CW{1'b0}};
        end
      end
    end
  end

  // Classify previous->current accepted pair {A,B}
  always_comb begin
    w_step_up = 1'b0;
    w_step_dn = 1'b0;
    w_illegal = 1'b0;
    case ({r_prev, r_acc})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: w_step_up = 1'b1;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: w_step_dn = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: w_illegal = 1'b1;
      default: begin
        w_step_up = 1'b0;
        w_step_dn = 1'b0;
        w_illegal = 1'b0;
      end
    endcase
  end

  // Strobes, direction, position and sticky error; clear beats a same-cycle step
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prev <= 2'b00;
      r_up   <= 1'b0;
      r_dn   <= 1'b0;
      r_pos  <= {N{1'b0}};
      r_dir  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_up <= i_ce & w_step_up;
      r_dn <= i_ce & w_step_dn;
      if (i_ce) begin
        r_prev <= r_acc;
        if (w_step_up) begin
          r_dir <= 1'b1;
        end else if (w_step_dn) begin
          r_dir <= 1'b0;
        end
      end
      if (i_clr) begin
        r_pos <= {N{1'b0}};
        r_err <= 1'b0;
      end else if (i_ce) begin
        if (w_step_up) begin
          r_pos <= r_pos + N'(1);
        end else if (w_step_dn) begin
          r_pos <= r_pos - N'(1);
        end
        if (w_illegal) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign o_count_up   = r_up;
  assign o_count_down = r_dn;
  assign o_position   = r_pos;
  assign o_dir        = r_dir;
  assign o_err        = r_err;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench for quadrature_decoder: each pin step pushes its expected strobe,
// a monitor pops and compares when the DUT strobes.
module tb_quadrature_decoder;

  typedef struct {
    logic [1:0] kind;   // {up, down}
    int         when;
    logic [7:0] pos;
    logic       dir;
  } exp_t;

  logic       i_clk;
  logic       i_reset_n;
  logic       i_ce;
  logic       i_a;
  logic       i_b;
  logic       i_clr;
  logic       o_count_up;
  logic       o_count_down;
  logic [7:0] o_position;
  logic       o_dir;
  logic       o_err;

  int   n_checks;
  int   n_errors;
  int   cyc;
  exp_t sb[$];
  exp_t mon_e;

  logic [7:0] m_pos;
  logic       m_dir;
  logic       m_err;
  logic [1:0] m_pins;

  quadrature_decoder #(.N(8), .FILT(3)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_a(i_a), .i_b(i_b),
    .i_clr(i_clr), .o_count_up(o_count_up), .o_count_down(o_count_down),
    .o_position(o_position), .o_dir(o_dir), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Position of a pair in the forward Gray cycle 00,10,11,01
  function automatic int gray_idx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Update the model for a new pin pair; push an expected strobe due at cycle 'when'
  task automatic apply_model(input logic [1:0] nxt, input int when);
    int   d;
    exp_t e;
    d = (gray_idx(nxt) - gray_idx(m_pins) + 4) % 4;
    if (d == 1 || d == 3) begin
      if (d == 1) begin
        m_pos = m_pos + 8'd1;
        m_dir = 1'b1;
        e.kind = 2'b10;
      end else begin
        m_pos = m_pos - 8'd1;
        m_dir = 1'b0;
        e.kind = 2'b01;
      end
      e.when = when;
      e.pos  = m_pos;
      e.dir  = m_dir;
      sb.push_back(e);
    end else if (d == 2) begin
      m_err = 1'b1;
    end
    m_pins = nxt;
  endtask

  task automatic step(input logic a, input logic b, input int hold);
    @(negedge i_clk);
    i_a = a;
    i_b = b;
    apply_model({a, b}, cyc + 6);
    repeat (hold - 1) @(negedge i_clk);
  endtask

  task automatic clear_pulse();
    @(negedge i_clk);
    i_clr = 1'b1;
    @(negedge i_clk);
    i_clr = 1'b0;
    m_pos = 8'd0;
    m_err = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pos"}, 32'(o_position), 32'(m_pos));
    check({tag, "_dir"}, 32'(o_dir), 32'(m_dir));
    check({tag, "_err"}, 32'(o_err), 32'(m_err));
  endtask

  // Strobe monitor: compare against scoreboard head, flag unexpected or overdue strobes
  always @(posedge i_clk) begin
    #1;
    if (o_count_up && o_count_down) check("both_strobes", 32'd1, 32'd0);
    if (o_count_up || o_count_down) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'({o_count_up, o_count_down}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_kind", 32'({o_count_up, o_count_down}), 32'(mon_e.kind));
        check("strobe_cycle", 32'(cyc), 32'(mon_e.when));
        check("strobe_pos", 32'(o_position), 32'(mon_e.pos));
        check("strobe_dir", 32'(o_dir), 32'(mon_e.dir));
      end
    end else if (sb.size() != 0 && sb[0].when < cyc) begin
      mon_e = sb.pop_front();
      check("missed_strobe_cycle", 32'(cyc), 32'(mon_e.when));
    end
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_pos     = 8'd0;
    m_dir     = 1'b0;
    m_err     = 1'b0;
    m_pins    = 2'b00;
    i_reset_n = 1'b0;
    i_ce      = 1'b1;
    i_clr     = 1'b0;
    i_a       = 1'b1;
    i_b       = 1'b1;

    // Reset with pins at 11; release gives an illegal 00->11 jump
    repeat (3) @(negedge i_clk);
    check("rst_up", 32'(o_count_up), 32'd0);
    check("rst_dn", 32'(o_count_down), 32'd0);
    check_state("rst");
    i_reset_n = 1'b1;
    apply_model(2'b11, cyc + 6);
    repeat (10) @(negedge i_clk);
    check_state("rel_illegal");
    step(1'b0, 1'b1, 10);
    step(1'b0, 1'b0, 10);
    check_state("rel_steps");
    clear_pulse();
    check_state("clr1");

    // Forward full cycle
    step(1'b1, 1'b0, 10);
    step(1'b1, 1'b1, 10);
    step(1'b0, 1'b1, 10);
    step(1'b0, 1'b0, 10);
    check_state("fwd");

    // Reverse through zero
    clear_pulse();
    step(1'b0, 1'b1, 10);
    step(1'b1, 1'b1, 10);
    step(1'b1, 1'b0, 10);
    check_state("rev_wrap");
    step(1'b0, 1'b0, 10);

    // Short glitch is filtered, FILT-long pulse gives up then down
    @(negedge i_clk);
    i_a = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_a = 1'b0;
    repeat (10) @(negedge i_clk);
    check_state("glitch2");
    step(1'b1, 1'b0, 3);
    step(1'b0, 1'b0, 12);
    check_state("glitch3");

    // Illegal jumps set the sticky error; clear drops it and the position
    step(1'b1, 1'b1, 10);
    check_state("illegal_a");
    step(1'b0, 1'b0, 10);
    check_state("illegal_b");
    clear_pulse();
    check_state("clr2");

    // Clock enable low freezes the filter; step lands 4 enabled edges after re-enable
    @(negedge i_clk);
    i_ce = 1'b0;
    i_a  = 1'b1;
    repeat (10) @(negedge i_clk);
    check_state("ce_hold");
    i_ce = 1'b1;
    apply_model(2'b10, cyc + 4);
    repeat (10) @(negedge i_clk);
    check_state("ce_resume");

    // Reset mid filter count: outputs drop at once, nothing fires afterwards
    @(negedge i_clk);
    i_a = 1'b1;
    i_b = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b0;
    i_a = 1'b0;
    i_b = 1'b0;
    #1;
    m_pos  = 8'd0;
    m_dir  = 1'b0;
    m_err  = 1'b0;
    m_pins = 2'b00;
    check("midrst_up", 32'(o_count_up), 32'd0);
    check("midrst_dn", 32'(o_count_down), 32'd0);
    check_state("midrst");
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (15) @(negedge i_clk);
    check_state("post_rst");
    check("sb_left", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
